// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit and the data memory it drives.
package lsu_pkg;
  localparam int ADDR_W_DEF    = 8;
  localparam int DATA_W_DEF    = 8;
  localparam int MEM_DEPTH_DEF = 192;

  localparam logic SIZE_BYTE = 1'b0;
  localparam logic SIZE_HALF = 1'b1;

  typedef enum logic [2:0] {
    IDLE, BEAT0, BEAT1, CAP_LO, CAP_HI, RESP
  } lsu_state_t;
endpackage

// File: rtl/load_store_unit.sv
// Sequences byte/halfword loads and stores onto an 8-bit registered-read data memory.
// Optional LSU_ADDR_CHECK_EN: flags requests whose beats fall outside MEM_DEPTH.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MEM_DEPTH = MEM_DEPTH_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic                req_size,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic                resp_valid,
  output logic [2*DATA_W-1:0] resp_rdata,
  output logic                resp_error,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W-1:0]   mem_write_data,
  output logic                mem_write_enable,
  input  logic [DATA_W-1:0]   mem_read_data
);

  lsu_state_t          state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   whi_q, whi_d;
  logic                write_q, write_d;
  logic                size_q, size_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                mem_we_q, mem_we_d;
  logic [2*DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic                resp_error_q, resp_error_d;
  logic                req_err;
  logic                accept;

`ifdef LSU_ADDR_CHECK_EN
  logic [ADDR_W-1:0] req_addr_inc;
  always_comb begin
    req_addr_inc = req_addr + ADDR_W'(1);
    req_err = (int'(req_addr) >= MEM_DEPTH) ||
              ((req_size == SIZE_HALF) && (int'(req_addr_inc) >= MEM_DEPTH));
  end
`else
  logic unused_depth;
  assign unused_depth = (MEM_DEPTH > 0);
  assign req_err      = 1'b0;
`endif

  assign req_ready = (state_q == IDLE) || (state_q == RESP);
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    whi_d         = whi_q;
    write_d       = write_q;
    size_d        = size_q;
    err_d         = err_q;
    lo_d          = lo_q;
    mem_address_d = mem_address_q;
    mem_wdata_d   = mem_wdata_q;
    mem_we_d      = mem_we_q;
    resp_rdata_d  = resp_rdata_q;
    resp_error_d  = resp_error_q;
    case (state_q)
      IDLE, RESP: begin
        mem_we_d = 1'b0;
        state_d  = IDLE;
        if (accept) begin
          addr_d        = req_addr;
          whi_d         = req_wdata[2*DATA_W-1:DATA_W];
          write_d       = req_write;
          size_d        = req_size;
          err_d         = req_err;
          mem_address_d = req_addr;
          mem_wdata_d   = req_wdata[DATA_W-1:0];
          // An out-of-range request still walks the full sequence, just without writing.
          mem_we_d      = req_write && !req_err;
          state_d       = BEAT0;
        end
      end
      BEAT0: begin
        if (size_q == SIZE_HALF) begin
          mem_address_d = addr_q + ADDR_W'(1);
          mem_wdata_d   = whi_q;
          state_d       = BEAT1;
        end else begin
          mem_we_d = 1'b0;
          state_d  = CAP_LO;
        end
      end
      BEAT1: begin
        // Low byte is staged so resp_rdata keeps the previous result until RESP.
        lo_d     = mem_read_data;
        mem_we_d = 1'b0;
        state_d  = CAP_HI;
      end
      CAP_LO: begin
        resp_rdata_d = (write_q || err_q) ? '0 : {{DATA_W{1'b0}}, mem_read_data};
        resp_error_d = err_q;
        state_d      = RESP;
      end
      CAP_HI: begin
        resp_rdata_d = (write_q || err_q) ? '0 : {mem_read_data, lo_q};
        resp_error_d = err_q;
        state_d      = RESP;
      end
      default: begin
        mem_we_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      whi_q         <= '0;
      write_q       <= 1'b0;
      size_q        <= SIZE_BYTE;
      err_q         <= 1'b0;
      lo_q          <= '0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
      mem_we_q      <= 1'b0;
      resp_rdata_q  <= '0;
      resp_error_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      whi_q         <= whi_d;
      write_q       <= write_d;
      size_q        <= size_d;
      err_q         <= err_d;
      lo_q          <= lo_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_we_q      <= mem_we_d;
      resp_rdata_q  <= resp_rdata_d;
      resp_error_q  <= resp_error_d;
    end
  end

  assign resp_valid       = (state_q == RESP);
  assign resp_rdata       = resp_rdata_q;
  assign resp_error       = resp_error_q;
  assign mem_address      = mem_address_q;
  assign mem_write_data   = mem_wdata_q;
  assign mem_write_enable = mem_we_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit against a registered-read byte memory.
module tb_load_store_unit;
`ifdef LSU_ADDR_CHECK_EN
  localparam int DEPTH = 192;
`else
  localparam int DEPTH = 256;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_write, req_size;
  logic        req_ready;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata;
  logic        resp_valid, resp_error;
  logic [15:0] resp_rdata;
  logic [7:0]  mem_address, mem_write_data, mem_read_data;
  logic        mem_write_enable;

  logic [7:0]  mem [256];
  int          vectors = 0;
  int          errors  = 0;

  always #5 clk = ~clk;

  // Data memory: registered read, read_data holds while write_enable=1.
  always @(posedge clk) begin
    if (mem_write_enable) mem[mem_address] <= mem_write_data;
    else                  mem_read_data    <= mem[mem_address];
  end

  load_store_unit #(.ADDR_W(8), .DATA_W(8), .MEM_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_write_enable(mem_write_enable), .mem_read_data(mem_read_data)
  );

  // Issue one request and wait for its response; lat counts edges from acceptance.
  task automatic do_req(input logic wr, input logic sz, input logic [7:0] a,
                        input logic [15:0] wd, output logic [15:0] rd,
                        output logic er, output int lat);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_addr = a; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1 lat++;
    end while (!resp_valid && lat < 10);
    rd = resp_rdata;
    er = resp_error;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 1'b0;
    req_addr = 8'h00; req_wdata = 16'h0000;
    repeat (2) @(negedge clk);
    vectors++;
    if ({req_ready, resp_valid, resp_rdata, resp_error, mem_address, mem_write_data, mem_write_enable}
        !== {1'b1, 1'b0, 16'h0000, 1'b0, 8'h00, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b rv=%b rd=%h re=%b ma=%h mwd=%h we=%b",
               req_ready, resp_valid, resp_rdata, resp_error, mem_address, mem_write_data, mem_write_enable);
    end
    reset = 1'b0;
  endtask

  task automatic test_byte();
    logic [15:0] rd; logic er; int lat;
    do_req(1'b1, 1'b0, 8'h42, 16'h00A5, rd, er, lat);
    vectors++;
    if ({rd, er, lat} !== {16'h0000, 1'b0, 32'd2}) begin
      errors++; $display("FAIL byte_store_resp: rd=%h er=%b lat=%0d want 0000/0/2", rd, er, lat);
    end
    vectors++;
    if (mem[8'h42] !== 8'hA5) begin
      errors++; $display("FAIL byte_store_mem: got %h want a5", mem[8'h42]);
    end
    do_req(1'b0, 1'b0, 8'h42, 16'h0000, rd, er, lat);
    vectors++;
    if ({rd, er, lat} !== {16'h00A5, 1'b0, 32'd2}) begin
      errors++; $display("FAIL byte_load: rd=%h er=%b lat=%0d want 00a5/0/2", rd, er, lat);
    end
  endtask

  task automatic test_half();
    logic [15:0] rd; logic er; int lat;
    do_req(1'b1, 1'b1, 8'h10, 16'hBEEF, rd, er, lat);
    vectors++;
    if ({rd, er, lat} !== {16'h0000, 1'b0, 32'd3}) begin
      errors++; $display("FAIL half_store_resp: rd=%h er=%b lat=%0d want 0000/0/3", rd, er, lat);
    end
    do_req(1'b0, 1'b0, 8'h10, 16'h0000, rd, er, lat);
    vectors++;
    if (rd !== 16'h00EF) begin errors++; $display("FAIL half_lo_byte: got %h want 00ef", rd); end
    do_req(1'b0, 1'b0, 8'h11, 16'h0000, rd, er, lat);
    vectors++;
    if (rd !== 16'h00BE) begin errors++; $display("FAIL half_hi_byte: got %h want 00be", rd); end
    do_req(1'b0, 1'b1, 8'h10, 16'h0000, rd, er, lat);
    vectors++;
    if ({rd, er, lat} !== {16'hBEEF, 1'b0, 32'd3}) begin
      errors++; $display("FAIL half_load: rd=%h er=%b lat=%0d want beef/0/3", rd, er, lat);
    end
    do_req(1'b1, 1'b1, 8'h31, 16'hC3D4, rd, er, lat);
    do_req(1'b0, 1'b1, 8'h31, 16'h0000, rd, er, lat);
    vectors++;
    if (rd !== 16'hC3D4) begin errors++; $display("FAIL half_odd_addr: got %h want c3d4", rd); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] rd; logic er; int lat; int n;
    do_req(1'b0, 1'b0, 8'h10, 16'h0000, rd, er, lat);
    // Still inside the RESP cycle: present the next load right away.
    req_valid = 1'b1; req_write = 1'b0; req_size = 1'b0; req_addr = 8'h42;
    vectors++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_in_resp: got %b want 1", req_ready); end
    @(posedge clk); #1 req_valid = 1'b0;
    vectors++;
    if ({resp_valid, req_ready} !== 2'b00) begin
      errors++; $display("FAIL b2b_accepted: rv=%b ready=%b want 0/0", resp_valid, req_ready);
    end
    n = 0;
    while (!resp_valid && n < 10) begin @(posedge clk); #1 n++; end
    vectors++;
    if ({resp_rdata, n} !== {16'h00A5, 32'd2}) begin
      errors++; $display("FAIL b2b_second_resp: rd=%h lat=%0d want 00a5/2", resp_rdata, n);
    end
    @(posedge clk); #1;
    vectors++;
    if ({resp_valid, resp_rdata} !== {1'b0, 16'h00A5}) begin
      errors++; $display("FAIL b2b_pulse_hold: rv=%b rd=%h want 0/00a5", resp_valid, resp_rdata);
    end
  endtask

`ifndef LSU_ADDR_CHECK_EN
  task automatic test_wrap();
    logic [15:0] rd; logic er; int lat;
    do_req(1'b1, 1'b1, 8'hFF, 16'h1234, rd, er, lat);
    vectors++;
    if ({mem[8'hFF], mem[8'h00]} !== 16'h3412) begin
      errors++; $display("FAIL wrap_store_mem: ff=%h 00=%h want 34/12", mem[8'hFF], mem[8'h00]);
    end
    do_req(1'b0, 1'b1, 8'hFF, 16'h0000, rd, er, lat);
    vectors++;
    if ({rd, er, lat} !== {16'h1234, 1'b0, 32'd3}) begin
      errors++; $display("FAIL wrap_load: rd=%h er=%b lat=%0d want 1234/0/3", rd, er, lat);
    end
  endtask
`else
  task automatic test_addr_check();
    logic [15:0] rd; logic er; int lat;
    do_req(1'b1, 1'b0, 8'hBF, 16'h0066, rd, er, lat);
    do_req(1'b1, 1'b1, 8'hBF, 16'hAAAA, rd, er, lat);
    vectors++;
    if ({rd, er, lat} !== {16'h0000, 1'b1, 32'd3}) begin
      errors++; $display("FAIL chk_store_resp: rd=%h er=%b lat=%0d want 0000/1/3", rd, er, lat);
    end
    vectors++;
    if (mem[8'hBF] !== 8'h66) begin errors++; $display("FAIL chk_no_write: got %h want 66", mem[8'hBF]); end
    do_req(1'b0, 1'b1, 8'hBE, 16'h0000, rd, er, lat);
    vectors++;
    if ({rd[15:8], er} !== {8'h66, 1'b0}) begin
      errors++; $display("FAIL chk_in_range: rdhi=%h er=%b want 66/0", rd[15:8], er);
    end
    do_req(1'b0, 1'b0, 8'hC0, 16'h0000, rd, er, lat);
    vectors++;
    if ({rd, er, lat} !== {16'h0000, 1'b1, 32'd2}) begin
      errors++; $display("FAIL chk_byte_oob: rd=%h er=%b lat=%0d want 0000/1/2", rd, er, lat);
    end
  endtask
`endif

  task automatic test_reset_mid_beat();
    logic [15:0] rd; logic er; int lat;
    do_req(1'b1, 1'b0, 8'h21, 16'h0077, rd, er, lat);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 1'b1; req_addr = 8'h20; req_wdata = 16'hAABB;
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    vectors++;
    if ({mem_write_enable, req_ready, resp_valid} !== 3'b010) begin
      errors++; $display("FAIL reset_mid_beat: we=%b ready=%b rv=%b want 0/1/0",
                         mem_write_enable, req_ready, resp_valid);
    end
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    vectors++;
    if (mem[8'h21] !== 8'h77) begin errors++; $display("FAIL reset_beat1_dropped: got %h want 77", mem[8'h21]); end
    do_req(1'b0, 1'b0, 8'h21, 16'h0000, rd, er, lat);
    vectors++;
    if ({rd, lat} !== {16'h0077, 32'd2}) begin
      errors++; $display("FAIL reset_recover_load: rd=%h lat=%0d want 0077/2", rd, lat);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    test_reset();
    test_byte();
    test_half();
    test_back_to_back();
`ifndef LSU_ADDR_CHECK_EN
    test_wrap();
`else
    test_addr_check();
`endif
    test_reset_mid_beat();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
